uart_rx: RTL and testbench

8-N-1 UART receiver: the receive end of the serial link whose transmit line the board top routes to a PMOD pin. It samples an asynchronous serial input at mid-bit, assembles bytes LSB-first, and holds each received byte in a single-entry register with a valid/ack handshake to on-chip logic. It reports framing and overrun errors as single-cycle pulses. It is instantiated in the chip top, with `rx` driven from a PMOD input pin.

---
 rtl/uart_rx.sv | 199 +++++++++++++++++++
 tb/tb_uart_rx.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8-N-1 UART receiver with mid-bit sampling, LSB-first assembly,
// a single-entry holding register with valid/ack handshake, and one-cycle
// frame_err / overrun pulses.
// Optional: define UART_RX_PARITY_EN for 8-E-1 framing with a parity_err pulse.
module uart_rx #(
  parameter int CLK_HZ = 100000000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
`ifdef UART_RX_PARITY_EN
  , output logic     parity_err
`endif
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
`ifdef UART_RX_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [2:0]      idx, idx_n;
  logic [7:0]      shreg, shreg_n;
  logic            rx_meta, rx_s;
  logic            commit;
  logic            ferr_n;
`ifdef UART_RX_PARITY_EN
  logic            par_ok, par_ok_n;
  logic            perr_n;
`endif

  // Two-flop synchronizer; flops idle high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // FSM state, bit timing counter, bit index and shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shreg <= shreg_n;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity check result, held from the parity sample until the stop sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_ok <= 1'b1;
    end else begin
      par_ok <= par_ok_n;
    end
  end
`endif

  // Next-state logic: mid-bit sampling, glitch rejection on the start bit.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shreg_n = shreg;
    commit  = 1'b0;
    ferr_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_ok_n = par_ok;
    perr_n   = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (!rx_s) begin
          state_n = S_START;
        end
      end
      S_START: begin
        if (cnt == CNT_HALF) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_n   = '0;
          shreg_n = {rx_s, shreg[7:1]};
          if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_n = S_PARITY;
`else
            state_n = S_STOP;
`endif
          end else begin
            idx_n = idx + 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt == CNT_LAST) begin
          cnt_n    = '0;
          par_ok_n = (rx_s == ^shreg);
          state_n  = S_STOP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_n   = '0;
          state_n = S_IDLE;
          ferr_n  = ~rx_s;
`ifdef UART_RX_PARITY_EN
          perr_n  = ~par_ok;
          commit  = rx_s & par_ok;
`else
          commit  = rx_s;
`endif
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Holding register and handshake; a commit coinciding with ack is not an overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr_n;
      overrun   <= 1'b0;
      if (commit) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
        overrun  <= rx_valid & ~rx_ack;
      end else if (rx_valid && rx_ack) begin
        rx_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  // One-cycle parity error pulse on the stop-sample cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= perr_n;
    end
  end
`endif

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed-vector bench for uart_rx at default parameters.
// Frames are driven bit-by-bit from the bench; expected values are hand-computed.
module tb_uart_rx;

  localparam int C = 868;
  localparam int H = 434;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS   = 11;
  localparam int LAT_NOM = 2 + H + 10 * C;
`else
  localparam int NBITS   = 10;
  localparam int LAT_NOM = 2 + H + 9 * C;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       frame_err;
  logic       overrun;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int ferrCount   = 0;
  int ovrCount    = 0;
  int perrCount   = 0;
  int riseAt      = -1;

  uart_rx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ack    (rx_ack),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
`ifdef UART_RX_PARITY_EN
    , .parity_err (parity_err)
`endif
  );

  always #5 clk = ~clk;

  // Count single-cycle error pulses, sampled on the falling edge.
  always @(negedge clk) begin
    if (frame_err) ferrCount++;
    if (overrun) ovrCount++;
`ifdef UART_RX_PARITY_EN
    if (parity_err) perrCount++;
`endif
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drives one frame; cycle e is the cycle following edge e, so ackAt is the
  // edge at which rx_ack is sampled high, and abortAt pulls rst_n mid-frame.
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input logic parBit,
                               input int ackAt, input int abortAt);
    logic [10:0] bits;
    logic        pv;
`ifdef UART_RX_PARITY_EN
    bits = {stopBit, parBit, data, 1'b0};
`else
    bits = {parBit, stopBit, data, 1'b0};
`endif
    riseAt = -1;
    pv = rx_valid;
    for (int e = 0; e < NBITS * C; e++) begin
      if (e == abortAt) begin
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_valid", 32'(rx_valid), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rx    = 1'b1;
        rst_n = 1'b1;
        return;
      end
      rx     = bits[e / C];
      rx_ack = (e == ackAt - 1);
      @(posedge clk);
      #1;
      if (!pv && rx_valid && riseAt < 0) riseAt = e + 1;
      pv = rx_valid;
    end
    rx     = 1'b1;
    rx_ack = 1'b0;
  endtask

  task automatic pulseAck();
    rx_ack = 1'b1;
    @(posedge clk);
    #1;
    rx_ack = 1'b0;
  endtask

  initial begin
    rst_n  = 1'b0;
    rx     = 1'b1;
    rx_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_valid", 32'(rx_valid), 32'd0);
    checkOutput("reset_data", 32'(rx_data), 32'h00);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_ferr", 32'(frame_err), 32'd0);
    checkOutput("reset_ovr", 32'(overrun), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Start-bit glitch: 200 low cycles is well short of the half-bit sample.
    rx = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    checkOutput("glitch_busy_hi", 32'(busy), 32'd1);
    repeat (100) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (600) @(posedge clk);
    #1;
    checkOutput("glitch_busy_lo", 32'(busy), 32'd0);
    checkOutput("glitch_valid", 32'(rx_valid), 32'd0);
    checkOutput("glitch_ferr", 32'(ferrCount), 32'd0);
    checkOutput("glitch_ovr", 32'(ovrCount), 32'd0);

    // 0x3C with a low stop bit: one frame_err pulse, nothing committed.
    applyStimulus(8'h3C, 1'b0, 1'b0, -1, -1);
    repeat (1000) @(posedge clk);
    #1;
    checkOutput("ferr_count", 32'(ferrCount), 32'd1);
    checkOutput("ferr_valid", 32'(rx_valid), 32'd0);
    checkOutput("ferr_data", 32'(rx_data), 32'h00);
    checkOutput("ferr_busy", 32'(busy), 32'd0);

    // 0xA5 clean frame, with latency window check.
    applyStimulus(8'hA5, 1'b1, 1'b0, -1, -1);
    checkOutput("a5_data", 32'(rx_data), 32'hA5);
    checkOutput("a5_valid", 32'(rx_valid), 32'd1);
    checkOutput("a5_latency", 32'(riseAt >= LAT_NOM - 1 && riseAt <= LAT_NOM + 1), 32'd1);
    checkOutput("a5_ferr", 32'(ferrCount), 32'd1);
    checkOutput("a5_ovr", 32'(ovrCount), 32'd0);
    pulseAck();
    checkOutput("a5_ack", 32'(rx_valid), 32'd0);

    // Back-to-back 0x11, 0x22 without ack: overrun on the second commit.
    applyStimulus(8'h11, 1'b1, 1'b0, -1, -1);
    checkOutput("b2b_first_data", 32'(rx_data), 32'h11);
    checkOutput("b2b_first_ovr", 32'(ovrCount), 32'd0);
    applyStimulus(8'h22, 1'b1, 1'b0, -1, -1);
    checkOutput("b2b_data", 32'(rx_data), 32'h22);
    checkOutput("b2b_valid", 32'(rx_valid), 32'd1);
    checkOutput("b2b_ovr", 32'(ovrCount), 32'd1);
    pulseAck();
    checkOutput("b2b_ack", 32'(rx_valid), 32'd0);
    pulseAck();
    checkOutput("idle_ack_valid", 32'(rx_valid), 32'd0);
    checkOutput("idle_ack_data", 32'(rx_data), 32'h22);

    // 0x11 pending, then 0x55 with ack landing on the commit edge: no overrun.
    applyStimulus(8'h11, 1'b1, 1'b0, -1, -1);
    checkOutput("ackc_pending", 32'(rx_data), 32'h11);
    applyStimulus(8'h55, 1'b1, 1'b0, LAT_NOM + 1, -1);
    checkOutput("ackc_data", 32'(rx_data), 32'h55);
    checkOutput("ackc_valid", 32'(rx_valid), 32'd1);
    checkOutput("ackc_ovr", 32'(ovrCount), 32'd1);
    pulseAck();

    // Reset during bit 4 of 0xFF, then a clean 0x0F.
    applyStimulus(8'hFF, 1'b1, 1'b0, -1, 5 * C + 400);
    repeat (100) @(posedge clk);
    #1;
    checkOutput("abort_idle", 32'(busy), 32'd0);
    checkOutput("abort_data", 32'(rx_data), 32'h00);
    applyStimulus(8'h0F, 1'b1, 1'b0, -1, -1);
    checkOutput("post_abort_data", 32'(rx_data), 32'h0F);
    checkOutput("post_abort_valid", 32'(rx_valid), 32'd1);
    checkOutput("post_abort_ferr", 32'(ferrCount), 32'd1);
    checkOutput("post_abort_ovr", 32'(ovrCount), 32'd1);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones, so even parity needs a 1; sending 0 must fail.
    checkOutput("par_none_yet", 32'(perrCount), 32'd0);
    applyStimulus(8'h07, 1'b1, 1'b0, -1, -1);
    checkOutput("par_count", 32'(perrCount), 32'd1);
    checkOutput("par_data", 32'(rx_data), 32'h0F);
    checkOutput("par_valid", 32'(rx_valid), 32'd1);
    checkOutput("par_ovr", 32'(ovrCount), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
